// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/retire controller of the
// non-pipelined core.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALTED = 3'd4,
    ST_FAULT  = 3'd5
  } fetch_state_e;

  // A redirect target must land on an instruction boundary.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential PC+4 or a redirect target,
// plus a flag for a redirect that is not word aligned.
module pc_next_calc
  import fetch_pkg::*;
#(
  parameter int XLEN = fetch_pkg::XLEN
) (
  input  logic [XLEN-1:0] pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] seq_pc;

  // Plain modular add: PC+4 past the top of the address space wraps to 0.
  assign seq_pc     = pc + XLEN'(INSTR_BYTES);
  assign next_pc    = redirect_valid ? redirect_target : seq_pc;
  assign misaligned = redirect_valid && is_misaligned(redirect_target[1:0]);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/retire controller: owns the PC, issues one instruction fetch at a
// time, presents it to execute and advances on retirement.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              XLEN         = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ack,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            halt,
  input  logic            resume,
  output logic [XLEN-1:0] pc_out,
  output logic [31:0]     retire_count,
  output logic            fault
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic [31:0]     retire_q;

  logic [XLEN-1:0] next_pc;
  logic            misaligned;
  logic            latch_instr;
  logic            do_retire;

  pc_next_calc #(
    .XLEN            (XLEN)
  ) u_pc_next_calc (
    .pc              (pc_q),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .next_pc         (next_pc),
    .misaligned      (misaligned)
  );

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d        = state_q;
    imem_req_valid = 1'b0;
    instr_valid    = 1'b0;
    fault          = 1'b0;
    latch_instr    = 1'b0;
    do_retire      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = halt ? ST_HALTED : ST_REQ;
      end

      ST_REQ: begin
        imem_req_valid = 1'b1;
        // An accepted request has to be followed through, so it beats halt.
        if (imem_req_ready) begin
          state_d = ST_WAIT;
        end else if (halt) begin
          state_d = ST_HALTED;
        end
      end

      ST_WAIT: begin
        if (imem_rsp_valid) begin
          latch_instr = 1'b1;
          state_d     = ST_EXEC;
        end
      end

      ST_EXEC: begin
        instr_valid = 1'b1;
        if (instr_ack) begin
          if (misaligned) begin
            state_d = ST_FAULT;
          end else begin
            do_retire = 1'b1;
            state_d   = halt ? ST_HALTED : ST_REQ;
          end
        end
      end

      ST_HALTED: begin
        if (resume && !halt) begin
          state_d = ST_REQ;
        end
      end

      ST_FAULT: begin
        fault = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_VECTOR;
      instr_q  <= '0;
      retire_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_instr) begin
        instr_q <= imem_rsp_data;
      end
      if (do_retire) begin
        pc_q     <= next_pc;
        retire_q <= retire_q + 32'd1;
      end
    end
  end

  // The PC only moves on retirement, so it is also the PC of the presented
  // instruction for the whole EXEC stay.
  assign imem_addr    = pc_q;
  assign pc_out       = pc_q;
  assign instr_pc     = pc_q;
  assign instr        = instr_q;
  assign retire_count = retire_q;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle fetch/retire controller that owns the program counter of the 32-bit non-pipelined processor. It issues one instruction-memory request at a time and presents the fetched instruction to the execute logic. It then waits for retirement and updates the PC with either PC+4 or a branch/jump redirect target. It also provides halt/resume control, a misaligned-target fault, and a retired-instruction counter.

## Interface
Parameters:
- XLEN, 32, address/data width
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  XLEN  fetch address (= pc_out)
- imem_rsp_valid  in  1  fetch data valid
- imem_rsp_data  in  32  fetched instruction
- instr_valid  out  1  instruction presented to execute
- instr  out  32  latched instruction
- instr_pc  out  XLEN  PC of presented instruction
- instr_ack  in  1  execute has retired the presented instruction
- redirect_valid  in  1  take redirect_target instead of PC+4 (sampled with instr_ack)
- redirect_target  in  XLEN  branch/jump target
- halt  in  1  stop at next instruction boundary
- resume  in  1  leave HALTED
- pc_out  out  XLEN  current PC
- retire_count  out  32  retired instructions, wraps
- fault  out  1  sticky misaligned-redirect fault

## Operation
- States: IDLE, REQ, WAIT, EXEC, HALTED, FAULT.
- IDLE: entered on reset. Next cycle goes to HALTED if halt=1, else REQ.
- REQ: imem_req_valid=1, imem_addr=pc_out held stable.
  - halt=1 with no handshake this cycle: go to HALTED.
  - On valid&ready: go to WAIT. A handshake takes priority over halt.
- WAIT: wait for imem_rsp_valid. On response, latch imem_rsp_data into instr and go to EXEC. halt is ignored here.
- EXEC: instr_valid=1, instr_pc=pc_out. On instr_ack:
  - redirect_valid=1 with redirect_target[1:0]!=0: go to FAULT, pc unchanged, retire_count unchanged.
  - Otherwise retire_count+=1 and pc <= redirect_valid ? redirect_target : pc+4 (mod 2^32).
  - Then go to HALTED if halt=1, else REQ.
- HALTED: no requests issued. resume=1 goes to REQ. If halt and resume are both high, halt wins (stay HALTED).
- FAULT: fault=1. No requests and no instr_valid. Left only by reset.
- imem_rsp_valid outside WAIT, and instr_ack/redirect_valid outside EXEC, are ignored.

## Timing
- Reset values: pc_out=RESET_VECTOR, imem_req_valid=0, instr_valid=0, instr=0, instr_pc=RESET_VECTOR, retire_count=0, fault=0, state=IDLE.
- imem_req_valid, instr_valid and fault decode combinationally from the state register. pc, instr and retire_count are registered.
- Minimum loop with ready=1, response one cycle after acceptance, and ack in the first EXEC cycle: REQ(1)+WAIT(1)+EXEC(1) = 3 cycles/instruction. The new PC is visible on imem_addr in the cycle after ack.
- The first request appears 2 cycles after reset deassertion (IDLE, then REQ).
- Reset mid-operation aborts any outstanding request. A late response after reset lands in IDLE/REQ and is ignored.

## Structure
- Package fetch_pkg: fetch_state_e enum, XLEN, INSTR_BYTES=4, RESET_VECTOR default.
- One combinational sub-module, pc_next_calc, takes pc, redirect_valid and redirect_target. It produces next_pc and a misaligned flag.
- The top level holds the FSM, pc/instr/retire_count registers and the handshake logic.

## Test plan
- Reset, ready=1, 1-cycle response, immediate ack: imem_addr sequence is 0x0, 0x4, 0x8; retire_count=3 after the third ack; each loop takes 3 cycles.
- Hold imem_req_ready=0 for 3 cycles in REQ: imem_req_valid stays 1 and imem_addr stays 0x0. The handshake occurs on cycle 4.
- Ack with redirect_valid=1 and target 0x100: next imem_addr=0x100 and retire_count increments.
- Ack with redirect target 0x102: fault=1, state FAULT, pc_out unchanged, no further imem_req_valid, retire_count unchanged.
- RESET_VECTOR=0xFFFF_FFFC, ack without redirect: next imem_addr=0x0000_0000.
- Halt and resume: halt=1 with ack in EXEC leads to HALTED with no requests for 5 cycles; resume=1 then produces a request at the old pc+4. Separately, assert reset during WAIT and then pulse imem_rsp_valid: the response is ignored, instr stays 0, and the first request goes to RESET_VECTOR.
